// File: rtl/multiword_cla_sequencer.sv
// Sequences a wide add/subtract through an external NBITS-wide CLA slice, one
// chunk per cycle (LS chunk first), chaining the carry and assembling the result.
module multiword_cla_sequencer #(
  parameter int unsigned NBITS  = 4,
  parameter int unsigned NWORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NBITS*NWORDS-1:0]   a_in,
  input  logic [NBITS*NWORDS-1:0]   b_in,
  input  logic                      cin,
  input  logic                      sub,
  output logic [NBITS-1:0]          cla_a,
  output logic [NBITS-1:0]          cla_b,
  output logic                      cla_cin,
  input  logic [NBITS-1:0]          cla_s,
  input  logic                      cla_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NBITS*NWORDS-1:0]   sum,
  output logic                      cout,
  output logic                      overflow
);

  localparam int unsigned W    = NBITS * NWORDS;
  localparam int unsigned IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic and chunk steering to the CLA
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cla_a   = '0;
    cla_b   = '0;
    cla_cin = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = sub ? ~b_in : b_in;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cla_a   = a_q[idx_q*NBITS +: NBITS];
        cla_b   = b_q[idx_q*NBITS +: NBITS];
        cla_cin = carry_q;
        sum_d[idx_q*NBITS +: NBITS] = cla_s;
        carry_d = cla_cout;
        if (idx_q == LAST) begin
          cout_d  = cla_cout;
          // Carry into the MSB recovered from the sum bit, XORed with carry out
          ovf_d   = (cla_a[NBITS-1] ^ cla_b[NBITS-1] ^ cla_s[NBITS-1]) ^ cla_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/multiword_cla_sequencer.md
Name: multiword_cla_sequencer

Overview:
- Sequential front/back end for the team's parameterized carry-lookahead adder (CLA) slice.
- Accepts one wide operand pair (NWORDS chunks of NBITS each) via valid/ready.
- Drives one chunk per cycle into an external NBITS-wide CLA, least-significant chunk first, and chains the returned carry into the next chunk.
- Assembles the wide sum/difference and presents it with carry, signed overflow and an output valid/ready handshake.

Parameters:
- NBITS, 4, chunk width; must match the attached CLA width.
- NWORDS, 4, chunks per operand; total width W = NBITS*NWORDS; minimum 1.

Ports:
- clk  input  1  sole clock; rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- a_in  input  W  operand A.
- b_in  input  W  operand B.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute A-B.
- cla_a  output  NBITS  chunk of A to CLA.
- cla_b  output  NBITS  chunk of B (inverted when sub) to CLA.
- cla_cin  output  1  chained carry to CLA.
- cla_s  input  NBITS  CLA sum, combinational from cla_a/cla_b/cla_cin.
- cla_cout  input  1  CLA carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  assembled result.
- cout  output  1  final carry-out; for sub, 1 = no borrow.
- overflow  output  1  two's-complement overflow of the W-bit operation.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; sum=0; cout=0; overflow=0; cla_a=0; cla_b=0; cla_cin=0; internal operand, index and carry registers cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1; cla_* driven 0.
  - On the edge where in_valid=1, latch a_in and b_in (b_in bitwise-inverted if sub), latch sub.
  - Set carry_reg = sub ? 1 : cin, idx=0, then go to RUN.
- RUN:
  - in_ready=0.
  - cla_a = a_reg[idx*NBITS +: NBITS]; cla_b = b_reg chunk idx; cla_cin = carry_reg. All are combinational from registers.
  - Each edge: sum chunk idx <= cla_s; carry_reg <= cla_cout; idx <= idx+1.
  - On the edge where idx==NWORDS-1: also cout <= cla_cout and overflow <= carry into the MSB XOR cla_cout. Carry into the MSB = cla_a[NBITS-1] ^ cla_b[NBITS-1] ^ cla_s[NBITS-1]. Then go to DONE.
  - NWORDS=1 finishes after one RUN cycle.
- DONE:
  - out_valid=1; in_ready=0; cla_* driven 0.
  - sum, cout and overflow are stable until the handshake.
  - On the edge where out_ready=1: out_valid<=0, go to IDLE.
  - No new operand is accepted on that same edge; in_ready rises the next cycle.
- Latency: with the accept edge as E0, out_valid is high after edge E(NWORDS). Throughput is one operation per NWORDS+2 cycles when out_ready is held at 1.
- sum is overwritten chunk-by-chunk during RUN; it is valid only while out_valid=1.
- Inputs a_in, b_in, cin and sub are ignored outside the IDLE accept edge. Changing them mid-RUN has no effect.
- Reset asserted mid-RUN or mid-DONE aborts immediately to reset values. No partial result is presented.
- idx width is max(1, clog2(NWORDS)). idx never exceeds NWORDS-1.

Test Plan (NBITS=4, NWORDS=4, bench includes CLA model):
- Add with carry wrap: A=0xFFFF, B=0x0001, cin=0, sub=0 -> after the 4th edge past accept: out_valid=1, sum=0x0000, cout=1, overflow=0. Observed cla_cin sequence is 0,1,1,1.
- Signed overflow: A=0x7FFF, B=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1. Also A=0x1234, B=0x4321, cin=1 -> sum=0x5556, cout=0, overflow=0.
- Subtract with borrow: sub=1, A=0x0003, B=0x0005, cin=1 (ignored) -> sum=0xFFFE, cout=0, overflow=0. Also A=0x8000, B=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/overflow stay stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> out_valid falls next edge, in_ready=1 the following cycle.
- Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle -> all outputs return to reset values asynchronously. Release, send A=0x0F0F, B=0x00F1, cin=0 -> sum=0x1000, cout=0.
- Back-to-back: out_ready tied 1, in_valid held 1 with three operand pairs -> accepts spaced 6 cycles apart, three correct results in order.
